mem_stage: RTL and testbench

MEM pipeline stage, directly downstream of the EX/MEM register. Contains:
- the data memory (synchronous write, byte/half/word lanes);
- load sign/zero extension;
- branch/jump resolution, driving the PC redirect back to fetch;
- the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/mem_stage_data_memory.sv | 27 ++
 rtl/mem_stage.sv | 127 ++++++++++++
 tb/tb_mem_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: access sizes, load/store opcodes, load lane extension.
// Pure constants and a combinational helper.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  // Signedness comes from the opcode alone; the lane width comes from MemSize.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input mem_size_e size, input logic [5:0] op);
    logic        sgn;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    sgn = (op == OP_LB) || (op == OP_LH);
    b   = word[{lane, 3'b000} +: 8];
    h   = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_HALF: res = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
      SIZE_BYTE: res = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
      default:   res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Data RAM: byte-lane write enables, registered read.
// Latency: read data valid one edge after re; no backpressure.
module data_memory #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              re,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data memory access, load extension, PC redirect and the MEM/WB register.
// Latency: 1 cycle to write-back, redirect/misalign combinational; no stall or backpressure.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        RegWrite_In,
  input  logic        MemToReg_In,
  input  logic [5:0]  OpCode_In,
  input  logic        Branch_In,
  input  logic        MemRead_In,
  input  logic        MemWrite_In,
  input  logic        Jump_In,
  input  logic        JumpRegister_In,
  input  logic        Link_In,
  input  logic [1:0]  MemSize_In,
  input  logic [31:0] JumpAddr_In,
  input  logic [31:0] BranchAddr_In,
  input  logic        ALUZero_In,
  input  logic [31:0] ALUResult_In,
  input  logic [31:0] ReadData2_In,
  input  logic [31:0] BranchTarget_In,
  input  logic [4:0]  WriteReg_In,
  output logic        PCSrc_Out,
  output logic [31:0] PCTarget_Out,
  output logic        Misaligned_Out,
  output logic        RegWrite_Out,
  output logic        MemToReg_Out,
  output logic        Link_Out,
  output logic [31:0] ReadData_Out,
  output logic [31:0] ALUResult_Out,
  output logic [4:0]  WriteReg_Out
);

  mem_size_e   size;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ram_rdata;
  logic        unused_addr_hi;

  mem_size_e   size_q;
  logic [1:0]  lane_q;
  logic [5:0]  op_q;
  logic        mem_read_q;

  assign size           = mem_size_e'(MemSize_In);
  assign unused_addr_hi = ^ALUResult_In[31:ADDR_W+2];

  // Narrow stores replicate their data across the word; byte enables pick the lane.
  always_comb begin
    be    = 4'b1111;
    wdata = ReadData2_In;
    case (size)
      SIZE_HALF: begin
        be    = ALUResult_In[1] ? 4'b1100 : 4'b0011;
        wdata = {2{ReadData2_In[15:0]}};
      end
      SIZE_BYTE: begin
        be    = 4'b0001 << ALUResult_In[1:0];
        wdata = {4{ReadData2_In[7:0]}};
      end
      default: ;
    endcase
  end

  data_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dmem (
    .Clk   (Clk),
    .we    (MemWrite_In && !Rst),
    .be    (be),
    .addr  (ALUResult_In[ADDR_W+1:2]),
    .wdata (wdata),
    .re    (MemRead_In),
    .rdata (ram_rdata)
  );

  always_comb begin
    Misaligned_Out = 1'b0;
    if (MemRead_In || MemWrite_In) begin
      case (size)
        SIZE_HALF: Misaligned_Out = ALUResult_In[0];
        SIZE_BYTE: Misaligned_Out = 1'b0;
        default:   Misaligned_Out = (ALUResult_In[1:0] != 2'b00);
      endcase
    end
  end

  always_comb begin
    PCSrc_Out    = 1'b1;
    PCTarget_Out = 32'h0;
    if (JumpRegister_In)            PCTarget_Out = BranchAddr_In;
    else if (Jump_In)               PCTarget_Out = JumpAddr_In;
    else if (Branch_In && ALUZero_In) PCTarget_Out = BranchTarget_In;
    else                            PCSrc_Out    = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      RegWrite_Out  <= 1'b0;
      MemToReg_Out  <= 1'b0;
      Link_Out      <= 1'b0;
      ALUResult_Out <= 32'h0;
      WriteReg_Out  <= 5'h0;
      mem_read_q    <= 1'b0;
      size_q        <= SIZE_WORD;
      lane_q        <= 2'b00;
      op_q          <= 6'h00;
    end else begin
      RegWrite_Out  <= RegWrite_In;
      MemToReg_Out  <= MemToReg_In;
      Link_Out      <= Link_In;
      ALUResult_Out <= ALUResult_In;
      WriteReg_Out  <= WriteReg_In;
      mem_read_q    <= MemRead_In;
      size_q        <= size;
      lane_q        <= ALUResult_In[1:0];
      op_q          <= OpCode_In;
    end
  end

  // The RAM word is already registered; only lane selection follows it.
  assign ReadData_Out = mem_read_q ? load_extend(ram_rdata, lane_q, size_q, op_q) : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a byte-array reference model.
module tb_mem_stage;

  localparam int DEPTH = 1024;
  localparam int BYTES = DEPTH * 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        RegWrite_In, MemToReg_In, Branch_In, MemRead_In, MemWrite_In;
  logic        Jump_In, JumpRegister_In, Link_In, ALUZero_In;
  logic [5:0]  OpCode_In;
  logic [1:0]  MemSize_In;
  logic [31:0] JumpAddr_In, BranchAddr_In, ALUResult_In, ReadData2_In, BranchTarget_In;
  logic [4:0]  WriteReg_In;
  logic        PCSrc_Out, Misaligned_Out, RegWrite_Out, MemToReg_Out, Link_Out;
  logic [31:0] PCTarget_Out, ReadData_Out, ALUResult_Out;
  logic [4:0]  WriteReg_Out;

  int checks = 0;
  int failures = 0;
  logic [7:0] ref_mem [BYTES];

  always #5 Clk = ~Clk;

  mem_stage #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
    .Clk(Clk), .Rst(Rst),
    .RegWrite_In(RegWrite_In), .MemToReg_In(MemToReg_In), .OpCode_In(OpCode_In),
    .Branch_In(Branch_In), .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In),
    .Jump_In(Jump_In), .JumpRegister_In(JumpRegister_In), .Link_In(Link_In),
    .MemSize_In(MemSize_In), .JumpAddr_In(JumpAddr_In), .BranchAddr_In(BranchAddr_In),
    .ALUZero_In(ALUZero_In), .ALUResult_In(ALUResult_In), .ReadData2_In(ReadData2_In),
    .BranchTarget_In(BranchTarget_In), .WriteReg_In(WriteReg_In),
    .PCSrc_Out(PCSrc_Out), .PCTarget_Out(PCTarget_Out), .Misaligned_Out(Misaligned_Out),
    .RegWrite_Out(RegWrite_Out), .MemToReg_Out(MemToReg_Out), .Link_Out(Link_Out),
    .ReadData_Out(ReadData_Out), .ALUResult_Out(ALUResult_Out), .WriteReg_Out(WriteReg_Out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input int a, input logic [1:0] sz, input logic [5:0] op);
    logic        sgn;
    int          hb, wb;
    logic [31:0] v;
    sgn = (op == 6'h20) || (op == 6'h21);
    if (sz == 2'b10) begin
      v = 32'(ref_mem[a]);
      if (sgn && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      hb = a - (a % 2);
      v  = 32'(ref_mem[hb]) + 256 * 32'(ref_mem[hb+1]);
      if (sgn && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      wb = a - (a % 4);
      v  = 32'(ref_mem[wb]) + 256 * 32'(ref_mem[wb+1]) + 65536 * 32'(ref_mem[wb+2])
         + 16777216 * 32'(ref_mem[wb+3]);
    end
    return v;
  endfunction

  task automatic model_store(input int a, input logic [1:0] sz, input logic [31:0] d);
    int base;
    if (sz == 2'b10) begin
      ref_mem[a] = d[7:0];
    end else if (sz == 2'b01) begin
      base = a - (a % 2);
      ref_mem[base]   = d[7:0];
      ref_mem[base+1] = d[15:8];
    end else begin
      base = a - (a % 4);
      for (int k = 0; k < 4; k++) ref_mem[base+k] = 8'((d >> (8 * k)) & 32'hFF);
    end
  endtask

  task automatic set_idle();
    RegWrite_In = 0; MemToReg_In = 0; Branch_In = 0; MemRead_In = 0; MemWrite_In = 0;
    Jump_In = 0; JumpRegister_In = 0; Link_In = 0; ALUZero_In = 0; OpCode_In = 6'h00;
    MemSize_In = 2'b00; JumpAddr_In = 0; BranchAddr_In = 0; ALUResult_In = 0;
    ReadData2_In = 0; BranchTarget_In = 0; WriteReg_In = 0;
  endtask

  task automatic set_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
    set_idle();
    MemWrite_In = 1; ALUResult_In = addr; ReadData2_In = data; MemSize_In = sz;
    OpCode_In = (sz == 2'b10) ? 6'h28 : (sz == 2'b01) ? 6'h29 : 6'h2B;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [1:0] sz, input logic [5:0] op);
    set_idle();
    MemRead_In = 1; MemToReg_In = 1; RegWrite_In = 1; ALUResult_In = addr;
    MemSize_In = sz; OpCode_In = op; WriteReg_In = 5'd9;
  endtask

  // Checks combinational outputs, advances one edge, then checks the MEM/WB outputs.
  task automatic cycle();
    logic        e_src, e_mis, e_rw, e_m2r, e_lnk;
    logic [31:0] e_tgt, e_rd, e_alu;
    logic [4:0]  e_wr;
    int          a;
    #1;
    e_src = 1; e_tgt = 0;
    if (JumpRegister_In) e_tgt = BranchAddr_In;
    else if (Jump_In) e_tgt = JumpAddr_In;
    else if (Branch_In && ALUZero_In) e_tgt = BranchTarget_In;
    else e_src = 0;
    a = int'(ALUResult_In % BYTES);
    e_mis = (MemRead_In || MemWrite_In) &&
            ((MemSize_In == 2'b01 && a % 2 != 0) ||
             ((MemSize_In == 2'b00 || MemSize_In == 2'b11) && a % 4 != 0));
    check_eq("pcsrc", 32'(PCSrc_Out), 32'(e_src));
    check_eq("pctarget", PCTarget_Out, e_tgt);
    check_eq("misaligned", 32'(Misaligned_Out), 32'(e_mis));
    e_rw  = Rst ? 1'b0 : RegWrite_In;
    e_m2r = Rst ? 1'b0 : MemToReg_In;
    e_lnk = Rst ? 1'b0 : Link_In;
    e_alu = Rst ? 32'h0 : ALUResult_In;
    e_wr  = Rst ? 5'h0 : WriteReg_In;
    e_rd  = (Rst || !MemRead_In) ? 32'h0 : model_load(a, MemSize_In, OpCode_In);
    if (MemWrite_In && !Rst) model_store(a, MemSize_In, ReadData2_In);
    @(posedge Clk);
    #1;
    check_eq("regwrite", 32'(RegWrite_Out), 32'(e_rw));
    check_eq("memtoreg", 32'(MemToReg_Out), 32'(e_m2r));
    check_eq("link", 32'(Link_Out), 32'(e_lnk));
    check_eq("aluresult", ALUResult_Out, e_alu);
    check_eq("writereg", 32'(WriteReg_Out), 32'(e_wr));
    check_eq("readdata", ReadData_Out, e_rd);
  endtask

  initial begin
    logic [5:0] ops [6];
    int r;
    ops[0] = 6'h20; ops[1] = 6'h21; ops[2] = 6'h23; ops[3] = 6'h24; ops[4] = 6'h25; ops[5] = 6'h00;

    set_idle();
    Rst = 1;
    RegWrite_In = 1; ALUResult_In = 32'h55; WriteReg_In = 5'd3; Link_In = 1;
    cycle();
    cycle();
    Rst = 0;

    // Give every word a known value so any later load has a defined expectation.
    for (int w = 0; w < DEPTH; w++) begin
      set_store(32'(w * 4), $urandom, 2'b00);
      cycle();
    end

    // Store then load the same word.
    set_store(32'h10, 32'hDEADBEEF, 2'b00); cycle();
    set_load(32'h10, 2'b00, 6'h23); cycle();
    check_eq("sw_lw", ReadData_Out, 32'hDEADBEEF);
    check_eq("sw_lw_rw", 32'(RegWrite_Out), 32'd1);

    // Byte store and signed/unsigned byte loads.
    set_store(32'h20, 32'h11223344, 2'b00); cycle();
    set_store(32'h21, 32'h00000080, 2'b10); cycle();
    set_load(32'h21, 2'b10, 6'h20); cycle();
    check_eq("lb", ReadData_Out, 32'hFFFFFF80);
    set_load(32'h21, 2'b10, 6'h24); cycle();
    check_eq("lbu", ReadData_Out, 32'h00000080);
    set_load(32'h20, 2'b00, 6'h23); cycle();
    check_eq("lw_after_sb", ReadData_Out, 32'h11228044);

    // Half store, loads, and a misaligned half load.
    set_store(32'h42, 32'h00008001, 2'b01); cycle();
    set_load(32'h42, 2'b01, 6'h21); cycle();
    check_eq("lh", ReadData_Out, 32'hFFFF8001);
    set_load(32'h42, 2'b01, 6'h25); cycle();
    check_eq("lhu", ReadData_Out, 32'h00008001);
    set_load(32'h43, 2'b01, 6'h21);
    #1 check_eq("lh_misaligned", 32'(Misaligned_Out), 32'd1);
    cycle();
    check_eq("lh_misaligned_data", ReadData_Out, 32'hFFFF8001);

    // Redirect priority.
    set_idle();
    Branch_In = 1; ALUZero_In = 1; BranchTarget_In = 32'h100; Jump_In = 1; JumpAddr_In = 32'h200;
    #1 check_eq("redir_jump", PCTarget_Out, 32'h200);
    cycle();
    Branch_In = 1; ALUZero_In = 1; BranchTarget_In = 32'h100; Jump_In = 1; JumpAddr_In = 32'h200;
    JumpRegister_In = 1; BranchAddr_In = 32'h300;
    #1 check_eq("redir_jr", PCTarget_Out, 32'h300);
    cycle();
    set_idle();
    Branch_In = 1; ALUZero_In = 0; BranchTarget_In = 32'h100;
    #1 check_eq("redir_none", 32'(PCSrc_Out), 32'd0);
    cycle();

    // Store during reset is dropped.
    set_store(32'h8, 32'hCAFEF00D, 2'b00); cycle();
    set_store(32'h8, 32'h12345678, 2'b00);
    RegWrite_In = 1; WriteReg_In = 5'd7; Link_In = 1;
    Rst = 1;
    cycle();
    Rst = 0;
    check_eq("rst_alu", ALUResult_Out, 32'h0);
    check_eq("rst_rw", 32'(RegWrite_Out), 32'd0);
    set_load(32'h8, 2'b00, 6'h23); cycle();
    check_eq("rst_store_dropped", ReadData_Out, 32'hCAFEF00D);

    // Address aliasing past the array size.
    set_store(32'h4, 32'hA5A5A5A5, 2'b00); cycle();
    set_load(32'h4 + 32'(BYTES), 2'b00, 6'h23); cycle();
    check_eq("alias", ReadData_Out, 32'hA5A5A5A5);

    // Random traffic: one instruction per cycle, never load and store together.
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      r = int'($urandom_range(0, 2));
      RegWrite_In = 1'($urandom); MemToReg_In = 1'($urandom); Link_In = 1'($urandom);
      WriteReg_In = 5'($urandom); ALUResult_In = $urandom; ReadData2_In = $urandom;
      MemSize_In = 2'($urandom); OpCode_In = ops[$urandom_range(0, 5)];
      MemRead_In = (r == 1); MemWrite_In = (r == 2);
      Branch_In = 1'($urandom); ALUZero_In = 1'($urandom);
      Jump_In = ($urandom_range(0, 3) == 0); JumpRegister_In = ($urandom_range(0, 3) == 0);
      JumpAddr_In = $urandom; BranchAddr_In = $urandom; BranchTarget_In = $urandom;
      Rst = ($urandom_range(0, 31) == 0);
      cycle();
    end
    Rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
